// File: rtl/result_checker.sv
// Snooping result monitor: arms on a begin symbol at the test port, then
// compares each later test-port write against a loadable expected table.
module result_checker #(
  parameter int                 ADDR_W    = 30,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  TEST_PORT = 30'h40,
  parameter logic [DATA_W-1:0]  BEGIN_SYM = 32'h00000932,
  parameter logic [DATA_W-1:0]  END_SYM   = 32'h00000D5D,
  parameter int                 IDX_W     = 6,
  parameter logic [15:0]        TIMEOUT   = 16'd60000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [IDX_W-1:0]  num_check,
  output logic [7:0]        error_num,
  output logic [15:0]       duration,
  output logic [IDX_W:0]    first_err,
  output logic              err_valid,
  output logic              finish,
  output logic              timeout,
  output logic              pass
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, CHECK, REPORT, TOUT} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t              state, state_n;
  logic                armed;
  logic [IDX_W:0]      ptr, ptr_n;
  logic [IDX_W-1:0]    nc_q, nc_n;
  logic [7:0]          err_n;
  logic [15:0]         dur_n;
  logic [IDX_W:0]      fe_n;
  logic                ev_n, fin_n, to_n, pass_n;
  logic [DATA_W-1:0]   exp_mem [DEPTH];

  logic                accept;
  logic                in_table;
  logic [DATA_W-1:0]   exp_word;
  logic                mismatch;
  logic                done;

  // Expected table: loaded only while idle, never reset so reruns need no reload.
  always_ff @(posedge clk) begin
    if (exp_we && state == IDLE)
      exp_mem[exp_idx] <= exp_data;
  end

  // One acceptance per wen pulse, however long a cache stall holds wen high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) armed <= 1'b1;
    else      armed <= ~wen;
  end

  assign accept   = wen && armed && (addr == TEST_PORT);
  assign in_table = ptr < {1'b0, nc_q};
  assign exp_word = in_table ? exp_mem[ptr[IDX_W-1:0]] : END_SYM;
  assign mismatch = accept && (data != exp_word);
  assign done     = accept && !in_table;

  always_comb begin
    state_n = state;
    err_n   = error_num;
    dur_n   = duration;
    ptr_n   = ptr;
    nc_n    = nc_q;
    fe_n    = first_err;
    ev_n    = err_valid;
    fin_n   = finish;
    to_n    = timeout;
    pass_n  = pass;
    case (state)
      IDLE: begin
        if (accept && data == BEGIN_SYM) begin
          state_n = CHECK;
          err_n   = 8'd0;
          dur_n   = 16'd0;
          ptr_n   = '0;
          ev_n    = 1'b0;
          nc_n    = num_check;
        end
      end
      CHECK: begin
        if (accept) ptr_n = ptr + 1'b1;
        if (mismatch) begin
          err_n = sat_inc8(error_num);
          if (!err_valid) begin
            fe_n = ptr;
            ev_n = 1'b1;
          end
        end
        // Completion wins over the watchdog when both land in one cycle.
        if (done) begin
          state_n = REPORT;
          fin_n   = 1'b1;
          pass_n  = (err_n == 8'd0);
          dur_n   = sat_inc16(duration);
        end else if (duration == TIMEOUT - 16'd1) begin
          state_n = TOUT;
          to_n    = 1'b1;
        end else begin
          dur_n   = sat_inc16(duration);
        end
      end
      REPORT: state_n = REPORT;
      TOUT:   state_n = TOUT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      error_num <= 8'd255;
      duration  <= 16'd0;
      first_err <= '0;
      err_valid <= 1'b0;
      finish    <= 1'b0;
      timeout   <= 1'b0;
      pass      <= 1'b0;
      ptr       <= '0;
      nc_q      <= '0;
    end else begin
      state     <= state_n;
      error_num <= err_n;
      duration  <= dur_n;
      first_err <= fe_n;
      err_valid <= ev_n;
      finish    <= fin_n;
      timeout   <= to_n;
      pass      <= pass_n;
      ptr       <= ptr_n;
      nc_q      <= nc_n;
    end
  end

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: directed and randomized runs scored by a
// transaction-level model of the expected verdict.
module tb_result_checker;

  localparam logic [29:0] TP        = 30'h40;
  localparam logic [31:0] BEGIN_SYM = 32'h00000932;
  localparam logic [31:0] END_SYM   = 32'h00000D5D;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        exp_we;
  logic [5:0]  exp_idx;
  logic [31:0] exp_data;
  logic [5:0]  num_check;

  logic [7:0]  error_num,    to_error_num;
  logic [15:0] duration,     to_duration;
  logic [6:0]  first_err,    to_first_err;
  logic        err_valid,    to_err_valid;
  logic        finish,       to_finish;
  logic        timeout,      to_timeout;
  logic        pass,         to_pass;

  result_checker dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data), .num_check(num_check),
    .error_num(error_num), .duration(duration), .first_err(first_err),
    .err_valid(err_valid), .finish(finish), .timeout(timeout), .pass(pass)
  );

  result_checker #(.TIMEOUT(16'd100)) dut_to (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data), .num_check(num_check),
    .error_num(to_error_num), .duration(to_duration), .first_err(to_first_err),
    .err_valid(to_err_valid), .finish(to_finish), .timeout(to_timeout), .pass(to_pass)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_tbl [64];
  logic [31:0] acc_q [$];
  int last_acc;
  int t_begin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Drive one write pulse holding wen for len cycles, then gap idle cycles.
  task automatic do_write(input logic [29:0] a, input logic [31:0] d, input int len, input int gap);
    @(negedge clk);
    addr = a; data = d; wen = 1'b1;
    if (a == TP) last_acc = cyc + 1;
    repeat (len) @(negedge clk);
    wen = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0; wen = 1'b0; exp_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_tbl(input bit rnd);
    int f [16];
    f[0] = 0; f[1] = 1;
    for (int i = 2; i < 16; i++) f[i] = f[i-1] + f[i-2];
    for (int i = 0; i < 64; i++) begin
      logic [31:0] v;
      if (rnd)         v = $urandom;
      else if (i < 16) v = f[i];
      else if (i < 32) v = f[31-i];
      else             v = 32'd0;
      @(negedge clk);
      exp_we = 1'b1; exp_idx = 6'(i); exp_data = v;
      model_tbl[i] = v;
    end
    @(negedge clk);
    exp_we = 1'b0;
  endtask

  // len==0 selects random stall lengths, gaps and stray non-test-port writes.
  task automatic run(input int nc, input int len, input int bad_a, input logic [31:0] bad_a_val,
                     input int bad_b, input string tag);
    int e, fe, t_end;
    bit ev;
    num_check = 6'(nc);
    acc_q.delete();
    do_write(TP, BEGIN_SYM, (len == 0) ? 1 : len, 0);
    t_begin = last_acc;
    @(negedge clk);
    exp_we = 1'b1; exp_idx = 6'd31; exp_data = 32'hDEADBEEF; num_check = 6'd3;
    @(negedge clk);
    exp_we = 1'b0;
    for (int i = 0; i <= nc; i++) begin
      logic [31:0] v;
      int l, g;
      v = (i < nc) ? model_tbl[i] : END_SYM;
      if (i == bad_a)      v = bad_a_val;
      else if (i == bad_b) v = v ^ 32'h00FF0000;
      l = (len == 0) ? int'($urandom_range(4, 1)) : len;
      g = (len == 0) ? int'($urandom_range(2, 0)) : 0;
      if (len == 0 && $urandom_range(3, 0) == 0) do_write(30'h41, v, 1, 0);
      do_write(TP, v, l, g);
      acc_q.push_back(v);
    end
    t_end = last_acc;
    repeat (2) @(negedge clk);
    e = 0; fe = 0; ev = 1'b0;
    for (int i = 0; i <= nc; i++) begin
      logic [31:0] expv;
      expv = (i < nc) ? model_tbl[i] : END_SYM;
      if (acc_q[i] != expv) begin
        if (e < 255) e++;
        if (!ev) begin fe = i; ev = 1'b1; end
      end
    end
    chk({tag, "_finish"},    32'(finish),    32'd1);
    chk({tag, "_timeout"},   32'(timeout),   32'd0);
    chk({tag, "_pass"},      32'(pass),      (e == 0) ? 32'd1 : 32'd0);
    chk({tag, "_error_num"}, 32'(error_num), 32'(e));
    chk({tag, "_err_valid"}, 32'(err_valid), 32'(ev));
    if (ev) chk({tag, "_first_err"}, 32'(first_err), 32'(fe));
    chk({tag, "_duration"},  32'(duration),  32'(t_end - t_begin));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    int rise;
    rst = 1'b0; addr = '0; data = '0; wen = 1'b0;
    exp_we = 1'b0; exp_idx = '0; exp_data = '0; num_check = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_error_num", 32'(error_num), 32'd255);
    chk("reset_duration",  32'(duration),  32'd0);
    chk("reset_first_err", 32'(first_err), 32'd0);
    chk("reset_err_valid", 32'(err_valid), 32'd0);
    chk("reset_finish",    32'(finish),    32'd0);
    chk("reset_timeout",   32'(timeout),   32'd0);
    chk("reset_pass",      32'(pass),      32'd0);

    load_tbl(1'b0);
    run(32, 1, -1, 32'd0, -1, "s1");
    reset_dut();
    run(32, 1, 5, 32'd7, 20, "s2");
    reset_dut();
    run(32, 4, -1, 32'd0, -1, "s3");
    reset_dut();
    run(0, 1, 0, 32'h1234, -1, "s4");

    reset_dut();
    num_check = 6'd4;
    do_write(TP, BEGIN_SYM, 1, 0);
    t_begin = last_acc;
    rise = -1;
    for (int k = 0; k < 300 && rise < 0; k++) begin
      @(negedge clk);
      if (to_timeout) rise = cyc;
    end
    chk("s5_rise_cycle", 32'(rise), 32'(t_begin + 100));
    chk("s5_timeout",    32'(to_timeout),  32'd1);
    chk("s5_finish",     32'(to_finish),   32'd0);
    chk("s5_pass",       32'(to_pass),     32'd0);
    chk("s5_duration",   32'(to_duration), 32'd99);
    chk("s5_main_busy",  32'(finish | timeout), 32'd0);

    reset_dut();
    do_write(30'h41, BEGIN_SYM, 1, 0);
    do_write(TP, 32'h1234, 1, 0);
    do_write(TP, END_SYM, 2, 0);
    @(negedge clk);
    addr = 30'h41; data = BEGIN_SYM; wen = 1'b1;
    @(negedge clk);
    addr = TP;
    @(negedge clk);
    wen = 1'b0;
    repeat (2) @(negedge clk);
    chk("s6_idle_error_num", 32'(error_num), 32'd255);
    chk("s6_idle_finish",    32'(finish),    32'd0);
    chk("s6_idle_duration",  32'(duration),  32'd0);
    num_check = 6'd32;
    do_write(TP, BEGIN_SYM, 1, 0);
    for (int i = 0; i < 3; i++) do_write(TP, model_tbl[i], 1, 0);
    @(negedge clk);
    chk("s6_armed_error_num", 32'(error_num), 32'd0);
    rst = 1'b0;
    #1;
    chk("s6_async_error_num", 32'(error_num), 32'd255);
    chk("s6_async_finish",    32'(finish),    32'd0);
    chk("s6_async_duration",  32'(duration),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    run(32, 1, -1, 32'd0, -1, "s6_rerun");

    for (int r = 0; r < 2; r++) begin
      int nc, ba, bb;
      reset_dut();
      load_tbl(1'b1);
      nc = int'($urandom_range(63, 1));
      ba = int'($urandom_range(nc, 0)) - (($urandom_range(1, 0) == 0) ? nc + 2 : 0);
      bb = int'($urandom_range(nc, 0));
      run(nc, 0, ba, $urandom, bb, (r == 0) ? "rand0" : "rand1");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
